// File: rtl/cpu_axi_pkg.sv
// Shared types and constants for the CPU-to-AXI3 bridge: FSM state encodings,
// fixed AXI attribute values and default transaction IDs.
package cpu_axi_pkg;

   typedef enum logic [1:0] {
      RD_IDLE = 2'd0,
      RD_AR   = 2'd1,
      RD_R    = 2'd2
   } rd_state_e;

   typedef enum logic [1:0] {
      WR_IDLE = 2'd0,
      WR_AW_W = 2'd1,
      WR_B    = 2'd2
   } wr_state_e;

   localparam logic [3:0] AXI_LEN        = 4'd0;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_LOCK       = 2'd0;
   localparam logic [3:0] AXI_CACHE      = 4'd0;
   localparam logic [2:0] AXI_PROT       = 3'd0;

   localparam logic [3:0] AXI_INST_ID    = 4'd0;
   localparam logic [3:0] AXI_DATA_ID    = 4'd1;

endpackage

// File: rtl/cpu_axi_bridge.sv
// Bridges the core's inst (read-only) and data SRAM-like ports onto one AXI3
// master: one read in flight on AR/R, one write in flight on AW/W/B.
module cpu_axi_bridge
   import cpu_axi_pkg::*;
#(
   parameter logic [3:0] INST_ID = AXI_INST_ID,
   parameter logic [3:0] DATA_ID = AXI_DATA_ID
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_sram_req,
   input  logic        inst_sram_wr,
   input  logic [1:0]  inst_sram_size,
   input  logic [31:0] inst_sram_addr,
   input  logic [3:0]  inst_sram_wstrb,
   input  logic [31:0] inst_sram_wdata,
   output logic        inst_sram_addrok,
   output logic        inst_sram_dataok,
   output logic [31:0] inst_sram_rdata,
   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [31:0] data_sram_addr,
   input  logic [3:0]  data_sram_wstrb,
   input  logic [31:0] data_sram_wdata,
   output logic        data_sram_addrok,
   output logic        data_sram_dataok,
   output logic [31:0] data_sram_rdata,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [3:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [3:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic [1:0]  awlock,
   output logic [3:0]  awcache,
   output logic [2:0]  awprot,
   output logic        awvalid,
   input  logic        awready,
   output logic [3:0]  wid,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   input  logic [3:0]  bid,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready,
   output logic [1:0]  o_rd_state,
   output logic [1:0]  o_wr_state
);

   rd_state_e   r_rd_state, w_rd_next;
   wr_state_e   r_wr_state, w_wr_next;
   logic        r_data_busy;
   logic [3:0]  r_arid;
   logic [31:0] r_araddr;
   logic [2:0]  r_arsize;
   logic [31:0] r_awaddr;
   logic [2:0]  r_awsize;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;
   logic        r_awvalid;
   logic        r_wvalid;

   logic w_rd_idle, w_wr_idle;
   logic w_data_rd_go, w_inst_rd_go;
   logic w_data_rd_hs, w_inst_rd_hs, w_data_wr_hs;
   logic w_r_hs, w_b_hs;
   logic w_unused;

   assign w_unused = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rresp, rlast, bid, bresp};

   assign w_rd_idle    = (r_rd_state == RD_IDLE);
   assign w_wr_idle    = (r_wr_state == WR_IDLE);
   // Data reads win the read channel on a tie with an inst fetch.
   assign w_data_rd_go = data_sram_req & ~data_sram_wr & ~r_data_busy;
   assign w_inst_rd_go = inst_sram_req & ~w_data_rd_go;
   assign w_data_rd_hs = w_rd_idle & w_data_rd_go;
   assign w_inst_rd_hs = w_rd_idle & w_inst_rd_go;
   assign w_data_wr_hs = w_wr_idle & data_sram_req & data_sram_wr & ~r_data_busy;
   assign w_r_hs       = (r_rd_state == RD_R) & rvalid;
   assign w_b_hs       = (r_wr_state == WR_B) & bvalid;

   assign inst_sram_addrok = w_rd_idle & ~w_data_rd_go;
   assign data_sram_addrok = ~r_data_busy & (data_sram_wr ? w_wr_idle : w_rd_idle);
   assign inst_sram_dataok = w_r_hs & (rid == INST_ID);
   assign data_sram_dataok = (w_r_hs & (rid == DATA_ID)) | w_b_hs;
   assign inst_sram_rdata  = rdata;
   assign data_sram_rdata  = rdata;

   assign arid    = r_arid;
   assign araddr  = r_araddr;
   assign arsize  = r_arsize;
   assign arlen   = AXI_LEN;
   assign arburst = AXI_BURST_INCR;
   assign arlock  = AXI_LOCK;
   assign arcache = AXI_CACHE;
   assign arprot  = AXI_PROT;
   assign arvalid = (r_rd_state == RD_AR);
   assign rready  = (r_rd_state == RD_R);

   assign awid    = DATA_ID;
   assign awaddr  = r_awaddr;
   assign awsize  = r_awsize;
   assign awlen   = AXI_LEN;
   assign awburst = AXI_BURST_INCR;
   assign awlock  = AXI_LOCK;
   assign awcache = AXI_CACHE;
   assign awprot  = AXI_PROT;
   assign awvalid = r_awvalid;
   assign wid     = DATA_ID;
   assign wdata   = r_wdata;
   assign wstrb   = r_wstrb;
   assign wlast   = 1'b1;
   assign wvalid  = r_wvalid;
   assign bready  = (r_wr_state == WR_B);

   assign o_rd_state = r_rd_state;
   assign o_wr_state = r_wr_state;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rd_state <= RD_IDLE;
         r_wr_state <= WR_IDLE;
      end else begin
         r_rd_state <= w_rd_next;
         r_wr_state <= w_wr_next;
      end
   end

   always_comb begin
      w_rd_next = r_rd_state;
      case (r_rd_state)
         RD_IDLE: if (w_data_rd_hs | w_inst_rd_hs) w_rd_next = RD_AR;
         RD_AR:   if (arready) w_rd_next = RD_R;
         RD_R:    if (rvalid) w_rd_next = RD_IDLE;
         default: w_rd_next = RD_IDLE;
      endcase
   end

   // AW and W may complete in either order; leave once neither is still pending.
   always_comb begin
      w_wr_next = r_wr_state;
      case (r_wr_state)
         WR_IDLE: if (w_data_wr_hs) w_wr_next = WR_AW_W;
         WR_AW_W: if ((~r_awvalid | awready) & (~r_wvalid | wready)) w_wr_next = WR_B;
         WR_B:    if (bvalid) w_wr_next = WR_IDLE;
         default: w_wr_next = WR_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_arid   <= 4'd0;
         r_araddr <= 32'd0;
         r_arsize <= 3'd0;
      end else if (w_data_rd_hs) begin
         r_arid   <= DATA_ID;
         r_araddr <= data_sram_addr;
         r_arsize <= {1'b0, data_sram_size};
      end else if (w_inst_rd_hs) begin
         r_arid   <= INST_ID;
         r_araddr <= inst_sram_addr;
         r_arsize <= {1'b0, inst_sram_size};
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_awaddr  <= 32'd0;
         r_awsize  <= 3'd0;
         r_wdata   <= 32'd0;
         r_wstrb   <= 4'd0;
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
      end else if (w_data_wr_hs) begin
         r_awaddr  <= data_sram_addr;
         r_awsize  <= {1'b0, data_sram_size};
         r_wdata   <= data_sram_wdata;
         r_wstrb   <= data_sram_wstrb;
         r_awvalid <= 1'b1;
         r_wvalid  <= 1'b1;
      end else begin
         if (awready) r_awvalid <= 1'b0;
         if (wready)  r_wvalid  <= 1'b0;
      end
   end

   // Single outstanding data access keeps loads ordered behind buffered stores.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_data_busy <= 1'b0;
      end else if (w_data_rd_hs | w_data_wr_hs) begin
         r_data_busy <= 1'b1;
      end else if (data_sram_dataok) begin
         r_data_busy <= 1'b0;
      end
   end

endmodule
